hm_round_sequencer: RTL

HM_ROUND_SEQUENCER -- requirements
Module: hm_round_sequencer

---
 rtl/hm_round_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/hm_round_sequencer.sv
// rtl/hm_round_sequencer.sv - round sequencer for an iterative hash core
// Steps IDLE->LOAD->ROUND x NUM_ROUNDS->ADD->DONE and cross-checks an external round timer.
module hm_round_sequencer #(
    parameter int NUM_ROUNDS = 64,
    parameter int IDX_W      = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             done_ack,
    input  logic             hash_rollover,
    output logic             busy,
    output logic             load_en,
    output logic             cnt_up,
    output logic             round_en,
    output logic [IDX_W-1:0] round_idx,
    output logic             add_en,
    output logic             done,
    output logic             sync_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_ADD,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] round_idx_q, round_idx_d;
    logic             load_en_q, load_en_d;
    logic             cnt_up_q, cnt_up_d;
    logic             round_en_q, round_en_d;
    logic             add_en_q, add_en_d;
    logic             done_q, done_d;
    logic             sync_err_q, sync_err_d;

    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        case (state_q)
            S_IDLE:  if (start && !abort) state_d = S_LOAD;
            S_LOAD: begin
                state_d     = S_ROUND;
                round_idx_d = '0;
            end
            S_ROUND: begin
                if (round_idx_q == LAST_IDX) begin
                    state_d     = S_ADD;
                    round_idx_d = '0;
                end else begin
                    round_idx_d = round_idx_q + IDX_W'(1);
                end
            end
            S_ADD:   state_d = S_DONE;
            S_DONE:  if (done_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            round_idx_d = '0;
        end

        // Outputs are registered, so they follow the state being entered.
        load_en_d  = (state_d == S_LOAD);
        cnt_up_d   = (state_d == S_ROUND);
        round_en_d = (state_d == S_ROUND);
        add_en_d   = (state_d == S_ADD);
        done_d     = (state_d == S_DONE);

        // The timer must roll over exactly in the ADD cycle and nowhere else.
        sync_err_d = sync_err_q | ((state_q == S_ADD) ? !hash_rollover : hash_rollover);
        if (state_q == S_IDLE && start && !abort) sync_err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            round_idx_q <= '0;
            load_en_q   <= 1'b0;
            cnt_up_q    <= 1'b0;
            round_en_q  <= 1'b0;
            add_en_q    <= 1'b0;
            done_q      <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
            load_en_q   <= load_en_d;
            cnt_up_q    <= cnt_up_d;
            round_en_q  <= round_en_d;
            add_en_q    <= add_en_d;
            done_q      <= done_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign load_en   = load_en_q;
    assign cnt_up    = cnt_up_q;
    assign round_en  = round_en_q;
    assign round_idx = round_idx_q;
    assign add_en    = add_en_q;
    assign done      = done_q;
    assign sync_err  = sync_err_q;

endmodule
